// File: rtl/sr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sr_pkg                                                       |
// | Description : Shared types and constants for the SR latch input            |
// |               conditioner: FSM state encoding, default debounce depth,     |
// |               and a counter-width helper.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sr_pkg;

   // Conditioner FSM states. The numeric encoding is fixed so that a probe on
   // the state register reads the same in every build.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE_S = 2'd1,
      PULSE_R = 2'd2,
      GAP     = 2'd3
   } sr_state_t;

   // Consecutive stable synchronised cycles before a debounced level moves.
   localparam int DEFAULT_DB_CYCLES = 4;

   // Default number of cycles S or R stays high per accepted request.
   localparam int DEFAULT_PULSE_W = 2;

   // Width of a counter that must hold the values 0 .. n_states-1.
   // Never returns less than one bit, so a single-state counter still has a
   // legal declaration.
   function automatic int cnt_width(input int n_states);
      return (n_states > 1) ? $clog2(n_states) : 1;
   endfunction

endpackage : sr_pkg
`default_nettype wire

// File: rtl/sr_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sr_debounce                                                  |
// | Description : One request channel: two-flop synchroniser, stability        |
// |               debouncer and rising-edge detector.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   raw    in   1  raw request, asynchronous to clk, may bounce
//   rise   out  1  one-cycle strobe when the debounced level goes 0 -> 1
//
// The debounced level only follows the synchronised input after it has
// disagreed with it for DB_CYCLES consecutive cycles; any cycle of agreement
// restarts the count. The rise strobe is decoded from two registers, so it is
// glitch-free and valid for exactly one clock.
module sr_debounce
   import sr_pkg::*;
#(
   parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic rise
);

   localparam int                c_cnt_w    = $clog2(DB_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_level;
   logic               r_level_d;
   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= raw;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;

         if (r_sync2 == r_level) begin
            // Input agrees with the accepted level: any partial count was a bounce.
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_last) begin
            // This is the DB_CYCLES-th consecutive disagreeing cycle.
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign rise = r_level & ~r_level_d;

endmodule : sr_debounce
`default_nettype wire

// File: rtl/sr_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sr_input_conditioner                                         |
// | Description : Drives the S/R inputs of a NOR SR latch from raw, bouncy     |
// |               set/reset requests. Requests are synchronised, debounced     |
// |               and turned into fixed-width, mutually exclusive pulses. A    |
// |               registered model of the latch Q is kept alongside.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Parameters
//   DB_CYCLES   stable synchronised cycles before a debounced level changes (>=1)
//   PULSE_W     cycles S or R is held high per accepted request (>=1)
//   RESET_WINS  1: same-cycle set+reset requests resolve to reset; 0: both dropped
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   set_raw    in   1  raw set request, asynchronous to clk
//   reset_raw  in   1  raw reset request, asynchronous to clk
//   S          out  1  registered set pulse to latch S
//   R          out  1  registered reset pulse to latch R
//   q_model    out  1  expected latch Q after the last issued pulse
//   conflict   out  1  one-cycle flag: set and reset requests in the same cycle
//   busy       out  1  high whenever the FSM is not in IDLE
module sr_input_conditioner
   import sr_pkg::*;
#(
   parameter int DB_CYCLES  = DEFAULT_DB_CYCLES,
   parameter int PULSE_W    = DEFAULT_PULSE_W,
   parameter int RESET_WINS = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_raw,
   input  logic reset_raw,
   output logic S,
   output logic R,
   output logic q_model,
   output logic conflict,
   output logic busy
);

   localparam int                 c_pcnt_w    = cnt_width(PULSE_W);
   localparam logic [c_pcnt_w-1:0] c_pcnt_last = c_pcnt_w'(PULSE_W - 1);
   localparam logic               c_reset_wins = (RESET_WINS != 0);

   // ------------------------------------------------------------------------
   // Request front end: one debounce channel per raw input
   // ------------------------------------------------------------------------
   logic w_set_req;
   logic w_rst_req;

   sr_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_set (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (set_raw),
      .rise  (w_set_req)
   );

   sr_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_rst (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (reset_raw),
      .rise  (w_rst_req)
   );

   // ------------------------------------------------------------------------
   // Request arbitration
   // ------------------------------------------------------------------------
   // A same-cycle set+reset pair is collapsed here into at most one effective
   // request, so the FSM below never has to see both at once.
   logic w_both;
   logic w_set_eff;
   logic w_rst_eff;
   logic w_opp_req;

   logic                r_q;
   logic                r_pend;
   logic                w_pend_next;
   logic [c_pcnt_w-1:0] r_pcnt;
   logic [c_pcnt_w-1:0] w_pcnt_next;
   sr_state_t           r_state;
   sr_state_t           w_state_next;

   assign w_both    = w_set_req & w_rst_req;
   assign w_set_eff = w_set_req & ~w_rst_req;
   assign w_rst_eff = w_rst_req & (~w_set_req | c_reset_wins);

   // While a pulse or its trailing gap is in progress, r_q already holds the
   // direction of that pulse, so the only request worth remembering is the
   // one that would move the latch the other way.
   assign w_opp_req = r_q ? w_rst_eff : w_set_eff;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pcnt  <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pcnt  <= w_pcnt_next;
         r_pend  <= w_pend_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state, pulse counter and pending flag
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_pcnt_next  = r_pcnt;
      w_pend_next  = r_pend;

      case (r_state)
         IDLE: begin
            w_pcnt_next = '0;
            w_pend_next = 1'b0;
            // A conflicting pair has already been reduced to a reset (or to
            // nothing) by the arbitration above; the conflict flag and the
            // resulting pulse start on the same clock edge.
            if (w_set_eff) begin
               w_state_next = PULSE_S;
            end else if (w_rst_eff) begin
               w_state_next = PULSE_R;
            end
         end

         PULSE_S, PULSE_R: begin
            if (w_opp_req) begin
               w_pend_next = 1'b1;
            end
            if (r_pcnt == c_pcnt_last) begin
               w_state_next = GAP;
               w_pcnt_next  = '0;
            end else begin
               w_pcnt_next = r_pcnt + 1'b1;
            end
         end

         GAP: begin
            w_pcnt_next = '0;
            // A request landing in the gap cycle itself is honoured directly
            // rather than being parked for an extra cycle.
            if (r_pend || w_opp_req) begin
               w_state_next = r_q ? PULSE_R : PULSE_S;
               w_pend_next  = 1'b0;
            end else begin
               w_state_next = IDLE;
            end
         end

         default: begin
            w_state_next = IDLE;
            w_pcnt_next  = '0;
            w_pend_next  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------------
   // S and R are decoded from the next state so they line up with the state
   // register; since the FSM holds one state at a time they are exclusive.
   logic r_s;
   logic r_r;
   logic r_conflict;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_q        <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_s        <= (w_state_next == PULSE_S);
         r_r        <= (w_state_next == PULSE_R);
         r_conflict <= w_both;
         if (w_state_next == PULSE_S) begin
            r_q <= 1'b1;
         end else if (w_state_next == PULSE_R) begin
            r_q <= 1'b0;
         end
      end
   end

   assign S        = r_s;
   assign R        = r_r;
   assign q_model  = r_q;
   assign conflict = r_conflict;
   assign busy     = (r_state != IDLE);

endmodule : sr_input_conditioner
`default_nettype wire

// File: tb/tb_sr_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sr_input_conditioner                                      |
// | Description : Directed testbench for sr_input_conditioner. A table of      |
// |               request patterns with hand-computed pulse windows, plus      |
// |               hand-written sequences for toggling input, reset during a    |
// |               pulse, re-request during a pulse and RESET_WINS=0.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Cycle c is the clock edge numbered c after rst_n is released; the raw inputs
// for cycle c are applied on the preceding falling edge and the outputs are
// sampled on the falling edge after edge c.
module tb_sr_input_conditioner;

   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic set_raw   = 1'b0;
   logic reset_raw = 1'b0;
   logic s, r, q_model, conflict, busy;

   // Second instance: short debounce, long pulse, conflicts dropped.
   logic set2   = 1'b0;
   logic reset2 = 1'b0;
   logic s2, r2, q2, conf2, busy2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sr_input_conditioner #(
      .DB_CYCLES  (4),
      .PULSE_W    (2),
      .RESET_WINS (1)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_raw   (set_raw),
      .reset_raw (reset_raw),
      .S         (s),
      .R         (r),
      .q_model   (q_model),
      .conflict  (conflict),
      .busy      (busy)
   );

   sr_input_conditioner #(
      .DB_CYCLES  (1),
      .PULSE_W    (6),
      .RESET_WINS (0)
   ) u_dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_raw   (set2),
      .reset_raw (reset2),
      .S         (s2),
      .R         (r2),
      .q_model   (q2),
      .conflict  (conf2),
      .busy      (busy2)
   );

   // Behavioural NOR latch driven by the main instance: S sets, R clears.
   logic latch_q;
   logic latch_nq;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)  latch_q <= 1'b0;
      else if (s)  latch_q <= 1'b1;
      else if (r)  latch_q <= 1'b0;
   end
   assign latch_nq = ~latch_q;

   task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      set_raw   = 1'b0;
      reset_raw = 1'b0;
      set2      = 1'b0;
      reset2    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      int   set_on;   // raw set high for set_on <= c < set_off (-1: never)
      int   set_off;
      int   rst_on;   // raw reset high for rst_on <= c < rst_off (-1: never)
      int   rst_off;
      int   s_first;  // first cycle S is high
      int   s_cnt;    // number of S cycles (0: none)
      int   r_first;
      int   r_cnt;
      int   conf_cyc; // cycle conflict is high (-1: never)
      logic q_end;
   } vec_t;

   localparam int NVEC = 9;
   localparam int NCYC = 16;
   vec_t vecs [NVEC];

   initial begin
      logic [2:0] exp3;
      logic       sv, rv, cv;
      vec_t       v;

      //          set_on off rst_on off s_first cnt r_first cnt conf  q
      vecs[0] = '{0,  16, -1, 0,   6,  2, -1, 0, -1, 1'b1}; // set alone
      vecs[1] = '{-1, 0,  0,  16, -1,  0,  6, 2, -1, 1'b0}; // reset alone
      vecs[2] = '{0,  16, 0,  16, -1,  0,  6, 2,  6, 1'b0}; // simultaneous -> reset wins
      vecs[3] = '{0,  16, 1,  16,  6,  2,  9, 2, -1, 1'b0}; // reset during PULSE_S -> pending
      vecs[4] = '{0,  16, 3,  16,  6,  2,  9, 2, -1, 1'b0}; // reset arrives in GAP cycle
      vecs[5] = '{0,  16, 4,  16,  6,  2, 10, 2, -1, 1'b0}; // reset arrives after back in IDLE
      vecs[6] = '{0,  3,  -1, 0,  -1,  0, -1, 0, -1, 1'b0}; // 3 raw cycles: too short
      vecs[7] = '{0,  4,  -1, 0,   6,  2, -1, 0, -1, 1'b1}; // 4 raw cycles: just enough
      vecs[8] = '{1,  16, 0,  16,  9,  2,  6, 2, -1, 1'b1}; // set during PULSE_R -> pending

      for (int i = 0; i < NVEC; i++) begin
         v = vecs[i];
         do_reset();
         chk($sformatf("v%0d_reset_outs", i), -1, {3'b0, s, r, q_model, conflict, busy}, 8'h00);
         for (int c = 0; c < NCYC; c++) begin
            set_raw   = (v.set_on >= 0) && (c >= v.set_on) && (c < v.set_off);
            reset_raw = (v.rst_on >= 0) && (c >= v.rst_on) && (c < v.rst_off);
            step();
            sv   = (v.s_cnt > 0) && (c >= v.s_first) && (c < v.s_first + v.s_cnt);
            rv   = (v.r_cnt > 0) && (c >= v.r_first) && (c < v.r_first + v.r_cnt);
            cv   = (c == v.conf_cyc);
            exp3 = {sv, rv, cv};
            chk($sformatf("v%0d_s_r_conf", i), c, {5'b0, s, r, conflict}, {5'b0, exp3});
         end
         chk($sformatf("v%0d_q_model", i), NCYC, {7'b0, q_model}, {7'b0, v.q_end});
         chk($sformatf("v%0d_latch_q_nq", i), NCYC, {6'b0, latch_q, latch_nq}, {6'b0, v.q_end, ~v.q_end});
      end

      // Raw set toggling every cycle never survives the debouncer.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         set_raw = (c < 8) && ((c % 2) == 0);
         step();
         chk("toggle_s_busy", c, {6'b0, s, busy}, 8'h00);
      end

      // Reset asserted in the middle of PULSE_S.
      do_reset();
      set_raw = 1'b1;
      for (int c = 0; c <= 6; c++) step();
      chk("pre_rst_s", 6, {7'b0, s}, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 6, {3'b0, s, r, q_model, conflict, busy}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_outs", -1, {3'b0, s, r, q_model, conflict, busy}, 8'h00);
      for (int c = 0; c < 10; c++) begin
         step();
         chk("relatency_s", c, {7'b0, s}, {7'b0, ((c == 6) || (c == 7))});
      end

      // Second set request during a (long) PULSE_S is dropped.
      do_reset();
      for (int c = 0; c < 16; c++) begin
         set2 = (c == 0) || ((c >= 2) && (c < 10));
         step();
         chk("dup_set_s_busy", c, {6'b0, s2, busy2},
             {6'b0, ((c >= 3) && (c <= 8)), ((c >= 3) && (c <= 9))});
      end
      chk("dup_set_q", 16, {7'b0, q2}, 8'h01);

      // RESET_WINS=0: simultaneous requests flag a conflict and do nothing else.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         set2   = 1'b1;
         reset2 = 1'b1;
         step();
         chk("drop_both", c, {4'b0, s2, r2, conf2, busy2}, (c == 3) ? 8'h02 : 8'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Latch must never see S and R together.
   always @(negedge clk) begin
      if (rst_n && (s & r)) begin
         bad++;
         total++;
         $display("FAIL s_and_r_both_high got=1 want=0");
      end
   end

endmodule : tb_sr_input_conditioner
`default_nettype wire
